// File: rtl/aes_ctrl_pkg.sv
// Shared encodings for the AES-128 inverse cipher sequencer and datapath.
// Optional abort input is enabled with the AES_CTRL_ABORT_EN macro.
package aes_ctrl_pkg;

  localparam int AES128_ROUNDS = 10;
  localparam int IMC_COLS      = 4;

  typedef enum logic [2:0] {
    FUNC_HALT = 3'd0,
    FUNC_LOAD = 3'd1,
    FUNC_ARK  = 3'd2,
    FUNC_ISR  = 3'd3,
    FUNC_ISB  = 3'd4,
    FUNC_IMC  = 3'd5
  } func_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ARK  = 3'd2,
    ST_ISR  = 3'd3,
    ST_ISB  = 3'd4,
    ST_IMC  = 3'd5,
    ST_DONE = 3'd6
  } ctrl_state_t;

  function automatic int sub_width(input int lat);
    int m;
    m = (lat > IMC_COLS) ? lat : IMC_COLS;
    return (m > 4) ? $clog2(m) : 2;
  endfunction

endpackage

// File: rtl/aes_round_cnt.sv
// Round and sub-step counters for the inverse cipher sequencer.
// Exposes next-state values so the FSM can register its outputs.
module aes_round_cnt
  import aes_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS   = AES128_ROUNDS,
  parameter int SUBBYTES_LAT = 1,
  parameter int SUB_W        = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rnd_clr_i,
  input  logic             rnd_inc_i,
  input  logic             sub_clr_i,
  input  logic             sub_inc_i,
  output logic [3:0]       rnd_d_o,
  output logic [SUB_W-1:0] sub_d_o,
  output logic             rnd_zero_o,
  output logic             rnd_last_o,
  output logic             isb_last_o,
  output logic             imc_last_o
);

  logic [3:0]       rnd_q, rnd_d;
  logic [SUB_W-1:0] sub_q, sub_d;

  always_comb begin
    rnd_d = rnd_q;
    if (rnd_clr_i)      rnd_d = '0;
    else if (rnd_inc_i) rnd_d = rnd_q + 4'd1;
  end

  always_comb begin
    sub_d = sub_q;
    if (sub_clr_i)      sub_d = '0;
    else if (sub_inc_i) sub_d = sub_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rnd_q <= '0;
      sub_q <= '0;
    end else begin
      rnd_q <= rnd_d;
      sub_q <= sub_d;
    end
  end

  assign rnd_d_o    = rnd_d;
  assign sub_d_o    = sub_d;
  assign rnd_zero_o = (rnd_q == 4'd0);
  assign rnd_last_o = (rnd_q == 4'(NUM_ROUNDS));
  assign isb_last_o = (sub_q == SUB_W'(SUBBYTES_LAT - 1));
  assign imc_last_o = (sub_q == SUB_W'(IMC_COLS - 1));

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// Sequencer for the shared AES-128 decryption datapath.
// Define AES_CTRL_ABORT_EN to add the AES_ABORT input.
module aes_inv_cipher_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS   = AES128_ROUNDS,
  parameter int SUBBYTES_LAT = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       AES_START,
`ifdef AES_CTRL_ABORT_EN
  input  logic       AES_ABORT,
`endif
  output logic       AES_DONE,
  output logic       BUSY,
  output logic       LOAD_STATE,
  output logic [2:0] FUNC,
  output logic [1:0] WORD_SEL,
  output logic [3:0] KEY_IDX,
  output logic       STATE_WE
);

  localparam int SUB_W = sub_width(SUBBYTES_LAT);

  ctrl_state_t      state_q, state_d;
  logic             rnd_clr, rnd_inc;
  logic             sub_clr, sub_inc;
  logic [3:0]       rnd_d;
  logic [SUB_W-1:0] sub_d;
  logic             rnd_zero, rnd_last;
  logic             isb_last, imc_last;
  logic             abort;

`ifdef AES_CTRL_ABORT_EN
  assign abort = AES_ABORT & BUSY;
`else
  assign abort = 1'b0;
`endif

  aes_round_cnt #(
    .NUM_ROUNDS  (NUM_ROUNDS),
    .SUBBYTES_LAT(SUBBYTES_LAT),
    .SUB_W       (SUB_W)
  ) u_cnt (
    .clk_i     (CLK),
    .rst_ni    (RESET),
    .rnd_clr_i (rnd_clr),
    .rnd_inc_i (rnd_inc),
    .sub_clr_i (sub_clr),
    .sub_inc_i (sub_inc),
    .rnd_d_o   (rnd_d),
    .sub_d_o   (sub_d),
    .rnd_zero_o(rnd_zero),
    .rnd_last_o(rnd_last),
    .isb_last_o(isb_last),
    .imc_last_o(imc_last)
  );

  always_comb begin
    state_d = state_q;
    rnd_clr = 1'b0;
    rnd_inc = 1'b0;
    sub_clr = 1'b0;
    sub_inc = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (AES_START) begin
          state_d = ST_LOAD;
          rnd_clr = 1'b1;
          sub_clr = 1'b1;
        end
      end
      ST_LOAD: state_d = ST_ARK;
      ST_ARK: begin
        if (rnd_zero) begin
          state_d = ST_ISR;
          rnd_inc = 1'b1;
        end else if (rnd_last) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_IMC;
          sub_clr = 1'b1;
        end
      end
      ST_ISR: begin
        state_d = ST_ISB;
        sub_clr = 1'b1;
      end
      ST_ISB: begin
        if (isb_last) state_d = ST_ARK;
        else          sub_inc = 1'b1;
      end
      ST_IMC: begin
        if (imc_last) begin
          state_d = ST_ISR;
          rnd_inc = 1'b1;
          sub_clr = 1'b1;
        end else begin
          sub_inc = 1'b1;
        end
      end
      ST_DONE: begin
        if (!AES_START) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort discards the operation; counters restart on the next request
    if (abort) begin
      state_d = ST_IDLE;
      rnd_clr = 1'b1;
      rnd_inc = 1'b0;
      sub_clr = 1'b1;
      sub_inc = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= ST_IDLE;
      AES_DONE   <= 1'b0;
      BUSY       <= 1'b0;
      LOAD_STATE <= 1'b0;
      FUNC       <= FUNC_HALT;
      WORD_SEL   <= '0;
      KEY_IDX    <= '0;
      STATE_WE   <= 1'b0;
    end else begin
      state_q    <= state_d;
      AES_DONE   <= (state_d == ST_DONE);
      BUSY       <= (state_d != ST_IDLE) && (state_d != ST_DONE);
      LOAD_STATE <= (state_d == ST_LOAD);
      WORD_SEL   <= (state_d == ST_IMC) ? 2'(sub_d) : 2'd0;
      KEY_IDX    <= (state_d == ST_ARK) ? 4'(NUM_ROUNDS) - rnd_d : 4'd0;
      unique case (state_d)
        ST_LOAD: begin FUNC <= FUNC_LOAD; STATE_WE <= 1'b1; end
        ST_ARK:  begin FUNC <= FUNC_ARK;  STATE_WE <= 1'b1; end
        ST_ISR:  begin FUNC <= FUNC_ISR;  STATE_WE <= 1'b1; end
        ST_ISB: begin
          FUNC     <= FUNC_ISB;
          STATE_WE <= (sub_d == SUB_W'(SUBBYTES_LAT - 1));
        end
        ST_IMC:  begin FUNC <= FUNC_IMC;  STATE_WE <= 1'b1; end
        default: begin FUNC <= FUNC_HALT; STATE_WE <= 1'b0; end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Directed bench for aes_inv_cipher_ctrl (default and SUBBYTES_LAT=2).
// Abort scenario is built when AES_CTRL_ABORT_EN is defined.
module tb_aes_inv_cipher_ctrl;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic AES_START = 1'b0;
  logic AES_ABORT = 1'b0;

  logic       d1_done, d1_busy, d1_ls, d1_we;
  logic [2:0] d1_func;
  logic [1:0] d1_word;
  logic [3:0] d1_key;
  logic       d2_done, d2_busy, d2_ls, d2_we;
  logic [2:0] d2_func;
  logic [1:0] d2_word;
  logic [3:0] d2_key;

  int n_cmp = 0;
  int n_err = 0;
  logic sel = 1'b0;

  always #5 CLK = ~CLK;

  aes_inv_cipher_ctrl dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .AES_START (AES_START),
`ifdef AES_CTRL_ABORT_EN
    .AES_ABORT (AES_ABORT),
`endif
    .AES_DONE  (d1_done),
    .BUSY      (d1_busy),
    .LOAD_STATE(d1_ls),
    .FUNC      (d1_func),
    .WORD_SEL  (d1_word),
    .KEY_IDX   (d1_key),
    .STATE_WE  (d1_we)
  );

  aes_inv_cipher_ctrl #(.NUM_ROUNDS(10), .SUBBYTES_LAT(2)) dut2 (
    .CLK       (CLK),
    .RESET     (RESET),
    .AES_START (AES_START),
`ifdef AES_CTRL_ABORT_EN
    .AES_ABORT (AES_ABORT),
`endif
    .AES_DONE  (d2_done),
    .BUSY      (d2_busy),
    .LOAD_STATE(d2_ls),
    .FUNC      (d2_func),
    .WORD_SEL  (d2_word),
    .KEY_IDX   (d2_key),
    .STATE_WE  (d2_we)
  );

  wire       m_done = sel ? d2_done : d1_done;
  wire       m_busy = sel ? d2_busy : d1_busy;
  wire       m_ls   = sel ? d2_ls   : d1_ls;
  wire       m_we   = sel ? d2_we   : d1_we;
  wire [2:0] m_func = sel ? d2_func : d1_func;
  wire [1:0] m_word = sel ? d2_word : d1_word;
  wire [3:0] m_key  = sel ? d2_key  : d1_key;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle(input string name);
    n_cmp++;
    if (m_done !== 1'b0 || m_busy !== 1'b0 || m_ls !== 1'b0 ||
        m_we !== 1'b0 || m_func !== 3'd0 || m_word !== 2'd0 ||
        m_key !== 4'd0) begin
      n_err++;
      $display("FAIL %s: got done=%b busy=%b ls=%b we=%b func=%0d word=%0d key=%0d want all 0",
               name, m_done, m_busy, m_ls, m_we, m_func, m_word, m_key);
    end
  endtask

  // Starts an operation from IDLE and walks it to DONE, checking each cycle.
  task automatic run_op(input logic s, input int exp_edge, input bit hold);
    int key, n_ark, n_isr, n_imc, isb_pos, done_at, lat;
    sel = s;
    lat = s ? 2 : 1;
    key = 10;
    n_ark = 0; n_isr = 0; n_imc = 0; isb_pos = 0;
    done_at = -1;
    AES_START = 1'b1;
    tick();
    if (!hold) AES_START = 1'b0;
    n_cmp++;
    if (m_func !== 3'd1 || m_ls !== 1'b1 || m_we !== 1'b1 || m_busy !== 1'b1) begin
      n_err++;
      $display("FAIL load: got func=%0d ls=%b we=%b busy=%b want 1 1 1 1",
               m_func, m_ls, m_we, m_busy);
    end
    for (int n = 1; n <= 200 && done_at < 0; n++) begin
      tick();
      if (m_func !== 3'd4) isb_pos = 0;
      if (m_done === 1'b1) begin
        done_at = n;
        n_cmp++;
        if (m_busy !== 1'b0 || m_func !== 3'd0 || m_we !== 1'b0) begin
          n_err++;
          $display("FAIL done_outs: got busy=%b func=%0d we=%b want 0 0 0",
                   m_busy, m_func, m_we);
        end
      end else begin
        case (m_func)
          3'd2: begin
            n_cmp++;
            if (m_key !== key[3:0] || m_we !== 1'b1 || m_busy !== 1'b1) begin
              n_err++;
              $display("FAIL ark_key: got key=%0d we=%b want key=%0d we=1",
                       m_key, m_we, key);
            end
            key--;
            n_ark++;
          end
          3'd3: n_isr++;
          3'd4: begin
            n_cmp++;
            if (m_we !== (isb_pos == lat - 1)) begin
              n_err++;
              $display("FAIL isb_we: got %b want %b at isb cycle %0d",
                       m_we, (isb_pos == lat - 1), isb_pos);
            end
            isb_pos++;
          end
          3'd5: begin
            n_cmp++;
            if (m_word !== 2'(n_imc % 4) || m_we !== 1'b1) begin
              n_err++;
              $display("FAIL imc_word: got %0d want %0d", m_word, n_imc % 4);
            end
            n_imc++;
          end
          default: begin
            n_cmp++;
            n_err++;
            $display("FAIL func: got %0d want 2..5 at edge %0d", m_func, n);
          end
        endcase
      end
    end
    n_cmp++;
    if (done_at != exp_edge) begin
      n_err++;
      $display("FAIL latency: got %0d want %0d", done_at, exp_edge);
    end
    n_cmp++;
    if (n_ark != 11 || n_isr != 10 || n_imc != 36) begin
      n_err++;
      $display("FAIL counts: got ark=%0d isr=%0d imc=%0d want 11 10 36",
               n_ark, n_isr, n_imc);
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    RESET = 1'b0;
    tick();
    check_idle("reset_edge1");
    tick();
    check_idle("reset_edge2");
    RESET = 1'b1;
    tick();
    check_idle("idle_after_reset");
  endtask

  task automatic test_nominal();
    run_op(1'b0, 68, 1'b0);
    tick();
    check_idle("idle_after_done");
  endtask

  task automatic test_back_to_back();
    run_op(1'b0, 68, 1'b0);
    tick();
    check_idle("idle_after_done2");
  endtask

  task automatic test_handshake();
    int bad;
    run_op(1'b0, 68, 1'b1);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      n_cmp++;
      if (d1_done !== 1'b1 || d1_func !== 3'd0 || d1_busy !== 1'b0) begin
        n_err++;
        bad++;
        if (bad < 4)
          $display("FAIL hold_done: got done=%b func=%0d busy=%b want 1 0 0",
                   d1_done, d1_func, d1_busy);
      end
    end
    AES_START = 1'b0;
    tick();
    check_idle("release_idle");
    AES_START = 1'b1;
    tick();
    AES_START = 1'b0;
    n_cmp++;
    if (d1_ls !== 1'b1 || d1_func !== 3'd1 || d1_busy !== 1'b1) begin
      n_err++;
      $display("FAIL restart: got ls=%b func=%0d busy=%b want 1 1 1",
               d1_ls, d1_func, d1_busy);
    end
  endtask

  // Continues the operation started by test_handshake (LOAD at edge 0).
  task automatic test_reset_mid();
    int seen;
    sel = 1'b0;
    for (int n = 1; n <= 28; n++) tick();
    n_cmp++;
    if (d1_func !== 3'd5 || d1_word !== 2'd2 || d1_busy !== 1'b1) begin
      n_err++;
      $display("FAIL mid_imc: got func=%0d word=%0d busy=%b want 5 2 1",
               d1_func, d1_word, d1_busy);
    end
    RESET = 1'b0;
    tick();
    check_idle("reset_mid1");
    tick();
    check_idle("reset_mid2");
    RESET = 1'b1;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (d1_done === 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL no_done_after_reset: got %0d done cycles want 0", seen);
    end
  endtask

  task automatic test_lat2();
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    run_op(1'b1, 78, 1'b0);
    tick();
    check_idle("lat2_idle");
    sel = 1'b0;
    check_idle("lat2_dut1_idle");
  endtask

`ifdef AES_CTRL_ABORT_EN
  task automatic test_abort();
    int seen;
    AES_START = 1'b1;
    tick();
    AES_START = 1'b0;
    for (int n = 1; n <= 19; n++) tick();
    n_cmp++;
    if (d1_busy !== 1'b1 || d2_busy !== 1'b1) begin
      n_err++;
      $display("FAIL pre_abort_busy: got %b %b want 1 1", d1_busy, d2_busy);
    end
    AES_ABORT = 1'b1;
    tick();
    AES_ABORT = 1'b0;
    sel = 1'b0;
    check_idle("abort_dut1");
    sel = 1'b1;
    check_idle("abort_dut2");
    seen = 0;
    for (int i = 0; i < 90; i++) begin
      tick();
      if (d1_done === 1'b1 || d2_done === 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL no_done_after_abort: got %0d want 0", seen);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_handshake();
    test_reset_mid();
    test_lat2();
`ifdef AES_CTRL_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
